// File: rtl/aes_frame_tx.sv
// Serial byte-load initiator for the AES core: captures block, key and mode in one cycle,
// then streams sync, data, key-size, key and operation beats with ready back-pressure.
module aes_frame_tx #(
    parameter int unsigned GAP = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] blk_in,
    input  logic [255:0] key_in,
    input  logic [1:0]   key_sel,
    input  logic         encrypt,
    output logic         tx_we,
    output logic [7:0]   tx_data,
    input  logic         tx_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYNC  = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] KSIZE = 3'd3;
    localparam logic [2:0] KEY   = 3'd4;
    localparam logic [2:0] OP    = 3'd5;
    localparam logic [2:0] GAPW  = 3'd6;
    localparam logic [2:0] FIN   = 3'd7;

    localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    logic [2:0] state;
    logic [2:0] resume;
    logic [2:0] beat_next;
    logic [5:0] cnt;
    logic [5:0] cnt_next;
    logic [5:0] nb;
    logic [3:0] gap_cnt;
    logic [1:0] key_sel_r;
    logic       enc_r;
    logic [7:0] blk_b [16];
    logic [7:0] key_b [32];
    logic [3:0] bidx;
    logic [4:0] kidx;
    logic       xfer;

    assign nb    = (key_sel_r == 2'd0) ? 6'd16 :
                   (key_sel_r == 2'd1) ? 6'd24 : 6'd32;
    assign bidx  = 4'd15 - cnt[3:0];
    // 5-bit wrap makes NB=32 index from 31 down without a sixth bit
    assign kidx  = nb[4:0] - 5'd1 - cnt[4:0];
    assign tx_we = state inside {SYNC, DATA, KSIZE, KEY, OP};
    assign xfer  = tx_we & tx_ready;
    assign busy  = (state != IDLE) && (state != FIN);
    assign done  = (state == FIN);

    always_comb begin
        tx_data = 8'h00;
        case (state)
            DATA:    tx_data = blk_b[bidx];
            KSIZE:   tx_data = {2'b00, nb};
            KEY:     tx_data = key_b[kidx];
            OP:      tx_data = {7'b0, enc_r};
            default: tx_data = 8'h00;
        endcase
    end

    always_comb begin
        beat_next = state;
        cnt_next  = cnt;
        case (state)
            SYNC: begin
                beat_next = DATA;
                cnt_next  = '0;
            end
            DATA: begin
                if (cnt == 6'd15) begin
                    beat_next = KSIZE;
                    cnt_next  = '0;
                end else begin
                    cnt_next = cnt + 6'd1;
                end
            end
            KSIZE: begin
                beat_next = KEY;
                cnt_next  = '0;
            end
            KEY: begin
                if (cnt == nb - 6'd1) begin
                    beat_next = OP;
                    cnt_next  = '0;
                end else begin
                    cnt_next = cnt + 6'd1;
                end
            end
            OP:      beat_next = FIN;
            default: beat_next = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            resume    <= IDLE;
            cnt       <= '0;
            gap_cnt   <= '0;
            key_sel_r <= '0;
            enc_r     <= 1'b0;
            err       <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) blk_b[i] <= '0;
            for (int unsigned i = 0; i < 32; i++) key_b[i] <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (key_sel == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < 16; i++) blk_b[i] <= blk_in[8*i +: 8];
                            for (int unsigned i = 0; i < 32; i++) key_b[i] <= key_in[8*i +: 8];
                            key_sel_r <= key_sel;
                            enc_r     <= encrypt;
                            cnt       <= '0;
                            state     <= SYNC;
                        end
                    end
                end
                GAPW: begin
                    if (gap_cnt == 4'd0) begin
                        state <= resume;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                FIN: state <= IDLE;
                default: begin
                    if (xfer) begin
                        cnt <= cnt_next;
                        if (GAP == 0) begin
                            state <= beat_next;
                        end else begin
                            state   <= GAPW;
                            resume  <= beat_next;
                            gap_cnt <= GAP_LD;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_frame_tx.sv
// Bench for aes_frame_tx: two instances (GAP=0 and GAP=2) driven in parallel and checked
// beat by beat against a frame list built from the load-format rules.
`timescale 1ns/1ps
module tb_aes_frame_tx;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] blk_in;
    logic [255:0] key_in;
    logic [1:0]   key_sel;
    logic         encrypt;
    logic         tx_ready;

    logic         we_o   [2];
    logic [7:0]   data_o [2];
    logic         busy_o [2];
    logic         done_o [2];
    logic         err_o  [2];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] frame[$];
    int         rd    [2];
    bit         pend  [2];
    int         pcyc  [2];
    bit         after [2];
    int         gz    [2];
    bit         hold  [2];
    logic [7:0] last  [2];
    logic       err_exp;

    localparam logic [127:0] FIPS_BLK = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] FIPS_KEY = {128'hffffffffffffffffffffffffffffffff,
                                         128'h000102030405060708090a0b0c0d0e0f};

    always #5 clk = ~clk;

    aes_frame_tx #(.GAP(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .blk_in(blk_in), .key_in(key_in),
        .key_sel(key_sel), .encrypt(encrypt), .tx_we(we_o[0]), .tx_data(data_o[0]),
        .tx_ready(tx_ready), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
    );

    aes_frame_tx #(.GAP(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .blk_in(blk_in), .key_in(key_in),
        .key_sel(key_sel), .encrypt(encrypt), .tx_we(we_o[1]), .tx_data(data_o[1]),
        .tx_ready(tx_ready), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int gapv(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // Expected beat list: sync, block MSB first, key size, key MSB-used-byte first, op.
    function automatic void push_frame(input logic [127:0] b, input logic [255:0] k,
                                       input logic [1:0] s, input logic e);
        int nb;
        frame.delete();
        rd[0] = 0;
        rd[1] = 0;
        nb = 16 + 8 * int'(s);
        frame.push_back(8'h00);
        for (int i = 15; i >= 0; i--) frame.push_back(b[8*i +: 8]);
        frame.push_back(8'(nb));
        for (int i = nb - 1; i >= 0; i--) frame.push_back(k[8*i +: 8]);
        frame.push_back({7'b0, e});
    endfunction

    function automatic void clear_model();
        frame.delete();
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; pend[d] = 0; pcyc[d] = 0; after[d] = 0; gz[d] = 0; hold[d] = 0;
        end
    endfunction

    task automatic monitor();
        for (int d = 0; d < 2; d++) begin
            if (pend[d]) pcyc[d]++;
            chk($sformatf("busy%0d", d), 32'(busy_o[d]),
                32'((rd[d] < frame.size()) || (pend[d] && !done_o[d])));
            chk($sformatf("err%0d", d), 32'(err_o[d]), 32'(err_exp));
            if (done_o[d]) begin
                chk($sformatf("done_delay%0d", d), pcyc[d], gapv(d) + 1);
                pend[d] = 0; pcyc[d] = 0; after[d] = 0;
            end
            if (hold[d]) begin
                chk($sformatf("hold_we%0d", d), 32'(we_o[d]), 1);
                chk($sformatf("hold_data%0d", d), 32'(data_o[d]), 32'(last[d]));
            end
            if (after[d] && we_o[d]) begin
                chk($sformatf("gap%0d", d), gz[d], gapv(d));
                after[d] = 0;
            end else if (after[d]) begin
                gz[d]++;
            end
            if (we_o[d] && tx_ready) begin
                if (rd[d] < frame.size()) begin
                    chk($sformatf("beat%0d_%0d", d, rd[d]), 32'(data_o[d]), 32'(frame[rd[d]]));
                    rd[d]++;
                    if (rd[d] == frame.size()) begin
                        pend[d] = 1; pcyc[d] = 0;
                    end
                end else begin
                    chk($sformatf("extra_beat%0d", d), 32'(we_o[d]), 0);
                end
                after[d] = 1; gz[d] = 0;
            end
            hold[d] = we_o[d] && !tx_ready;
            last[d] = data_o[d];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        blk_in  = {$urandom, $urandom, $urandom, $urandom};
        key_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key_sel = 2'($urandom_range(0, 3));
        encrypt = 1'($urandom);
    endtask

    // mode 0: ready high; 1: random ready; 2: directed stalls; 3: random ready + mid-frame start
    task automatic run_frame(input int mode, input int nbeats);
        bit got [2];
        int first;
        int busyc;
        got[0] = 0; got[1] = 0; first = -1; busyc = 0;
        for (int cyc = 0; cyc < 1000 && !(got[0] && got[1]); cyc++) begin
            case (mode)
                0:       tx_ready = 1'b1;
                2:       tx_ready = !((cyc >= 6 && cyc <= 8) || (cyc >= 20 && cyc <= 22));
                default: tx_ready = ($urandom_range(0, 3) != 0);
            endcase
            start = (mode == 3 && cyc == 10);
            if (cyc == 5) scramble();
            @(negedge clk);
            if (mode == 2 && cyc >= 6 && cyc <= 8)   chk("stall_byte5", 32'(data_o[0]), 32'h55);
            if (mode == 2 && cyc >= 20 && cyc <= 22) chk("stall_ksize", 32'(data_o[0]), 32'h10);
            if (we_o[0] && first < 0) first = cyc;
            if (busy_o[0] && !got[0]) busyc++;
            if (mode == 0 && done_o[0] && !got[0]) begin
                chk("done_latency", cyc - first, nbeats);
                chk("busy_length", busyc, nbeats);
            end
            for (int d = 0; d < 2; d++) if (done_o[d]) got[d] = 1;
            monitor();
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        tx_ready = 1'b1;
        chk("frame_done0", 32'(got[0]), 1);
        chk("frame_done2", 32'(got[1]), 1);
    endtask

    task automatic send(input logic [127:0] b, input logic [255:0] k, input logic [1:0] s,
                        input logic e, input int mode);
        blk_in = b; key_in = k; key_sel = s; encrypt = e; start = 1'b1;
        tick();
        start = 1'b0;
        push_frame(b, k, s, e);
        run_frame(mode, frame.size());
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_we%0d", tag, d),   32'(we_o[d]),   0);
            chk($sformatf("%s_data%0d", tag, d), 32'(data_o[d]), 0);
            chk($sformatf("%s_busy%0d", tag, d), 32'(busy_o[d]), 0);
            chk($sformatf("%s_done%0d", tag, d), 32'(done_o[d]), 0);
            chk($sformatf("%s_err%0d", tag, d),  32'(err_o[d]),  0);
        end
    endtask

    initial begin
        logic [255:0] k;
        reset = 1'b1; start = 1'b0; blk_in = '0; key_in = '0; key_sel = '0;
        encrypt = 1'b0; tx_ready = 1'b1; err_exp = 1'b0;
        clear_model();
        #1;
        chk_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        send(FIPS_BLK, FIPS_KEY, 2'd0, 1'b1, 0);

        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(31 - i);
        send(128'($urandom), k, 2'd2, 1'b0, 0);

        k = '1;
        for (int i = 0; i < 24; i++) k[8*i +: 8] = 8'(23 - i);
        send({$urandom, $urandom, $urandom, $urandom}, k, 2'd1, 1'b1, 0);

        send(FIPS_BLK, FIPS_KEY, 2'd0, 1'b1, 2);

        send(FIPS_BLK, FIPS_KEY, 2'd0, 1'b1, 3);
        repeat (60) tick();
        send(FIPS_BLK, FIPS_KEY, 2'd0, 1'b0, 0);

        key_sel = 2'd3; start = 1'b1;
        tick();
        start = 1'b0; err_exp = 1'b1;
        tick();
        err_exp = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk("illegal_we0", 32'(we_o[0]), 0);
            chk("illegal_we2", 32'(we_o[1]), 0);
            tick();
        end

        // Reset during the KEY phase of dut0, with a start held across the reset edge.
        blk_in = FIPS_BLK; key_in = FIPS_KEY; key_sel = 2'd0; encrypt = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        push_frame(FIPS_BLK, FIPS_KEY, 2'd0, 1'b1);
        repeat (22) tick();
        reset = 1'b1;
        start = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        clear_model();
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        send(FIPS_BLK, FIPS_KEY, 2'd0, 1'b1, 1);

        for (int n = 0; n < 6; n++)
            send({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 2'($urandom_range(0, 2)), 1'($urandom), 1);

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
